// File: rtl/conv_enc_frame_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_enc_frame_ctrl_if                                                     |
// | Frame control, message-bit and code-symbol handshakes of the encoder.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface conv_enc_frame_ctrl_if #(
  parameter int LEN_W = 10
);
  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic             err_len;
  logic             in_bit;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       out_sym;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic             done;

  modport master (
    output start, frame_len, in_bit, in_valid, out_ready,
    input  err_len, in_ready, out_sym, out_valid, out_last, busy, done
  );

  modport slave (
    input  start, frame_len, in_bit, in_valid, out_ready,
    output err_len, in_ready, out_sym, out_valid, out_last, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/conv_enc_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_enc_frame_ctrl                                                        |
// | K=4 rate-1/2 convolutional encoder frame sequencer with zero-tail flush.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module conv_enc_frame_ctrl #(
  parameter int LEN_W     = 10,
  parameter int TAIL_BITS = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  conv_enc_frame_ctrl_if.slave       bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_TAIL  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] c_LEN_ONE   = LEN_W'(1);
  localparam logic [1:0]       c_TAIL_LAST = 2'(TAIL_BITS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_sr;        // [0]=d1 (newest), [1]=d2, [2]=d3
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_bit_cnt;
  logic [1:0]       r_tail_cnt;
  logic [1:0]       r_out_sym;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_busy;
  logic             r_done;
  logic             r_err_len;

  logic             w_slot_free;
  logic             w_load;
  logic             w_u;
  logic             w_last;
  logic             w_start_ok;
  logic             w_start_err;
  logic             w_finish;
  logic [1:0]       w_sym;

  assign w_slot_free = !r_out_valid || bus.out_ready;
  assign w_sym       = {w_u ^ r_sr[0] ^ r_sr[1] ^ r_sr[2], w_u ^ r_sr[0] ^ r_sr[2]};

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_u         = 1'b0;
    w_last      = 1'b0;
    w_start_ok  = 1'b0;
    w_start_err = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.frame_len != '0) begin
            w_start_ok  = 1'b1;
            w_state_nxt = S_DATA;
          end else begin
            w_start_err = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (bus.in_valid && w_slot_free) begin
          w_load = 1'b1;
          w_u    = bus.in_bit;
          if (r_bit_cnt == r_len - c_LEN_ONE) begin
            w_state_nxt = S_TAIL;
          end
        end
      end
      S_TAIL: begin
        if (w_slot_free) begin
          w_load = 1'b1;
          if (r_tail_cnt == c_TAIL_LAST) begin
            w_last      = 1'b1;
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (r_out_valid && bus.out_ready) begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sr        <= '0;
      r_len       <= '0;
      r_bit_cnt   <= '0;
      r_tail_cnt  <= '0;
      r_out_sym   <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_len   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_done    <= w_finish;
      r_err_len <= w_start_err;
      if (w_start_ok) begin
        r_len      <= bus.frame_len;
        r_bit_cnt  <= '0;
        r_tail_cnt <= '0;
        r_sr       <= '0;
        r_busy     <= 1'b1;
      end
      // A load during a handshake simply overwrites the slot, keeping valid high.
      if (w_load) begin
        r_out_sym   <= w_sym;
        r_out_last  <= w_last;
        r_out_valid <= 1'b1;
        r_sr        <= {r_sr[1:0], w_u};
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
      if (w_load && (r_state == S_DATA)) begin
        r_bit_cnt <= r_bit_cnt + c_LEN_ONE;
      end
      if (w_load && (r_state == S_TAIL)) begin
        r_tail_cnt <= r_tail_cnt + 2'd1;
      end
      if (w_finish) begin
        r_busy <= 1'b0;
        r_sr   <= '0;
      end
    end
  end

  assign bus.in_ready  = (r_state == S_DATA) && w_slot_free;
  assign bus.out_sym   = r_out_sym;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err_len   = r_err_len;

endmodule
`default_nettype wire

// File: doc/conv_enc_frame_ctrl.md
Name: conv_enc_frame_ctrl

Overview:
Frame sequencer for the K=4, rate-1/2 convolutional encoder datapath (generators G1=1111, G0=1101). It accepts a frame length and a start command, then pulls message bits over a valid/ready handshake. It appends K-1=3 zero tail bits so the trellis returns to state 0, and emits 2-bit code symbols over a backpressured valid/ready output. It embeds its own enable-gated 3-bit encoder shift register and sits between the framing logic and the modulator/symbol FIFO.

Parameters:
LEN_W, 10, width of frame_len; the maximum frame is 2^LEN_W-1 message bits.
TAIL_BITS, 3, zero flush bits appended per frame; fixed at K-1, and no other value is supported.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  one-cycle frame start command; honoured only in IDLE.
frame_len  input  LEN_W  message-bit count, sampled when start is honoured.
err_len  output  1  one-cycle pulse when start arrives with frame_len==0.
in_bit  input  1  message bit.
in_valid  input  1  in_bit is valid.
in_ready  output  1  controller accepts in_bit this cycle.
out_sym  output  2  code symbol; bit1 = G1 output, bit0 = G0 output.
out_valid  output  1  out_sym is valid.
out_ready  input  1  downstream accepts out_sym.
out_last  output  1  qualifies the final symbol of the frame (the last tail symbol).
busy  output  1  high from accepted start until the frame completes.
done  output  1  one-cycle pulse when the frame completes.

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE; shift register, bit counter and tail counter =0; out_sym=2'b00; out_valid, out_last, in_ready, busy, done, err_len =0.
- Encoder: state d1,d2,d3 (d1 = most recent bit). For input u:
  - out_sym[1] = u^d1^d2^d3
  - out_sym[0] = u^d1^d3
  - then d3<=d2, d2<=d1, d1<=u.
  - The register advances only when a symbol is loaded.
- slot_free = !out_valid || out_ready. The output register is single-entry. out_sym and out_last hold stable while out_valid && !out_ready.
- FSM states: IDLE, DATA, TAIL, DRAIN.
- IDLE:
  - busy=0, in_ready=0.
  - start && frame_len!=0: latch frame_len, clear the shift register and counters, go to DATA, busy=1 next cycle.
  - start && frame_len==0: err_len=1 for one cycle, stay in IDLE.
- DATA:
  - in_ready = slot_free (combinational).
  - On in_valid && in_ready: encode in_bit, load the output register, set out_valid=1 next cycle (latency 1 cycle), increment the bit counter.
  - After the frame_len-th accepted bit, go to TAIL.
  - in_valid with in_ready=0 is held by upstream and not lost.
- TAIL:
  - in_ready=0.
  - Each cycle with slot_free, encode u=0 and load the output register.
  - The 3rd tail symbol loads with out_last=1; go to DRAIN.
- DRAIN:
  - Wait for out_valid && out_ready on the last symbol.
  - Next cycle: done=1 for one cycle, busy=0, out_valid=0 (unless replaced), state=IDLE, shift register back to 0.
- Symbols per frame: exactly frame_len+3. With out_ready held at 1 and in_valid held at 1, one symbol is produced per cycle with no bubbles.
- Simultaneous events:
  - An output handshake and a new load in the same cycle: the new symbol replaces the old one, and out_valid stays 1.
  - start while busy=1 is ignored, with no err_len.
  - frame_len changes after start have no effect.
- out_last=0 on every symbol except the final tail symbol.
- Reset mid-frame aborts the frame immediately: no done, the pending symbol is discarded, and the next frame starts from state 0.
- No combinational path from in_valid to out_valid. in_ready depends only on registered out_valid and on out_ready.

Test Plan:
- Reset then idle: all outputs 0 → start with frame_len=4, bits 1,0,1,1, in_valid=1, out_ready=1 → out_sym sequence 11,11,01,11,01,01,11; out_last only on the 7th symbol; done pulses one cycle after it; busy falls with done.
- Impulse, frame_len=1, bit 1 → 11,11,10,11. Then frame_len=2, bits 0,0 → 00,00,00,00,00, confirming the state was cleared between frames.
- Backpressure: frame_len=4 as above with out_ready toggling 1,0,0,1,… → out_sym stable while stalled; in_ready=0 during stalls; same 7 symbols in order; no drops or duplicates.
- Upstream gaps: in_valid asserted every 3rd cycle → symbols appear 1 cycle after each acceptance; tail symbols follow back-to-back.
- Errors and ignores: start with frame_len=0 → err_len pulse, busy stays 0. A start mid-frame is ignored, and the frame completes normally.
- rst asserted after 2 symbols of a 4-bit frame → outputs 0 asynchronously. A subsequent frame_len=1, bit 1 frame yields 11,11,10,11.
